// File: rtl/seqdet_sched.sv
// seqdet_sched: shares one serial "10010" Mealy detector among N_REQ requesters, one word at a time.
// Define SEQDET_SCHED_FIXED_PRIO_EN for fixed lowest-index priority; default build is round-robin.
module seqdet_sched #(
    parameter int N_REQ  = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(WORD_W + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [N_REQ*WORD_W-1:0] i_data,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [N_REQ-1:0]        o_done,
    output logic [CNT_W-1:0]        o_hit_cnt,
    output logic                    o_busy,
    output logic                    o_det_rst,
    output logic                    o_det_j,
    input  logic                    i_det_w
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam int BIT_W = $clog2(WORD_W);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_GRANT  = 3'd1;
    localparam logic [2:0] S_CLR    = 3'd2;
    localparam logic [2:0] S_SHIFT  = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W-1:0]  r_owner;
    logic [PTR_W-1:0]  w_pick;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W:0]    w_sum;
    logic [WORD_W-1:0] r_sh;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [CNT_W-1:0]  r_hitCnt;
    logic [CNT_W-1:0]  r_hitOut;
    logic              r_detRst;

    // Search from the pointer upward with wrap; scanning high offsets first leaves the nearest winner.
    always_comb begin
        w_pick = '0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(N_REQ))
                w_sum = w_sum - (PTR_W + 1)'(N_REQ);
            w_idx = w_sum[PTR_W-1:0];
            if (i_req[w_idx])
                w_pick = w_idx;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|i_req) w_next = S_GRANT;
            S_GRANT:  w_next = S_CLR;
            S_CLR:    w_next = S_SHIFT;
            S_SHIFT:  if (r_bitCnt == '0) w_next = S_REPORT;
            S_REPORT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_sh     <= '0;
            r_bitCnt <= '0;
            r_hitCnt <= '0;
            r_hitOut <= '0;
            r_detRst <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_detRst <= (w_next == S_CLR);
            case (r_state)
                S_IDLE: begin
                    if (|i_req)
                        r_owner <= w_pick;
                end
                S_GRANT: begin
                    r_sh     <= i_data[r_owner*WORD_W +: WORD_W];
                    r_hitCnt <= '0;
                end
                S_CLR: begin
                    r_bitCnt <= BIT_W'(WORD_W - 1);
                end
                S_SHIFT: begin
                    r_sh     <= {r_sh[WORD_W-2:0], 1'b0};
                    r_bitCnt <= r_bitCnt - 1'b1;
                    if (i_det_w)
                        r_hitCnt <= r_hitCnt + 1'b1;
                    // The reported count must include a hit on the final bit.
                    if (r_bitCnt == '0)
                        r_hitOut <= r_hitCnt + CNT_W'(i_det_w);
                end
                S_REPORT: begin
`ifdef SEQDET_SCHED_FIXED_PRIO_EN
                    r_ptr <= '0;
`else
                    if (r_owner == PTR_W'(N_REQ - 1))
                        r_ptr <= '0;
                    else
                        r_ptr <= r_owner + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_gnt  = '0;
        o_done = '0;
        if (r_state == S_GRANT)
            o_gnt[r_owner] = 1'b1;
        if (r_state == S_REPORT)
            o_done[r_owner] = 1'b1;
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_det_rst = r_detRst;
    assign o_det_j   = (r_state == S_SHIFT) & r_sh[WORD_W-1];
    assign o_hit_cnt = r_hitOut;

endmodule

// File: tb/tb_seqdet_sched.sv
// tb_seqdet_sched: drives seqdet_sched with a behavioural 10010 detector attached to det_*,
// predicting grants and hit counts into a scoreboard that an independent monitor drains.
module tb_seqdet_sched;
    localparam int N_REQ       = 4;
    localparam int WORD_W      = 8;
    localparam int CNT_W       = $clog2(WORD_W + 1);
    localparam int GNT_TO_DONE = WORD_W + 2;
    localparam int WAIT_LIMIT  = 40;

    typedef struct {
        int owner;
        int hits;
    } expDone_t;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*WORD_W-1:0] data;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    logic [CNT_W-1:0]        hitCnt;
    logic                    busy;
    logic                    detRst;
    logic                    detJ;
    logic                    detW;

    int nCompared   = 0;
    int nMismatched = 0;
    int cycle       = 0;

    int       expGntQ[$];
    expDone_t expDoneQ[$];

    logic [N_REQ-1:0]  reqVec;
    logic [WORD_W-1:0] words [N_REQ];
    int                ptrModel = 0;

    seqdet_sched #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_data    (data),
        .o_gnt     (gnt),
        .o_done    (done),
        .o_hit_cnt (hitCnt),
        .o_busy    (busy),
        .o_det_rst (detRst),
        .o_det_j   (detJ),
        .i_det_w   (detW)
    );

    always #5 clk = ~clk;

    // External 10010 Mealy detector; dState is the length of the matched prefix.
    logic [2:0] dState;
    always @(posedge clk) begin
        if (detRst)
            dState <= 3'd0;
        else
            case (dState)
                3'd0:    dState <= detJ ? 3'd1 : 3'd0;
                3'd1:    dState <= detJ ? 3'd1 : 3'd2;
                3'd2:    dState <= detJ ? 3'd1 : 3'd3;
                3'd3:    dState <= detJ ? 3'd4 : 3'd0;
                3'd4:    dState <= detJ ? 3'd1 : 3'd2;
                default: dState <= 3'd0;
            endcase
    end
    assign detW = (dState == 3'd4) && !detJ;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int pickOwner(input logic [N_REQ-1:0] r, input int p);
`ifdef SEQDET_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N_REQ; i++)
            if (r[i]) return i;
`else
        for (int k = 0; k < N_REQ; k++)
            if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
`endif
        return 0;
    endfunction

    // Overlapping occurrences of 10010 inside one word; nothing carries between words.
    function automatic int countHits(input logic [WORD_W-1:0] w);
        int n = 0;
        logic [WORD_W-1:0] t;
        for (int i = 0; i + 5 <= WORD_W; i++) begin
            t = w >> i;
            if (t[4:0] == 5'b10010) n++;
        end
        return n;
    endfunction

    function automatic logic [N_REQ*WORD_W-1:0] slot(input int i, input logic [WORD_W-1:0] w);
        logic [N_REQ*WORD_W-1:0] v = '0;
        v[i*WORD_W +: WORD_W] = w;
        return v;
    endfunction

    task automatic driveBus();
        req = reqVec;
        for (int i = 0; i < N_REQ; i++)
            data[i*WORD_W +: WORD_W] = words[i];
    endtask

    task automatic predict(output int owner);
        expDone_t e;
        owner   = pickOwner(reqVec, ptrModel);
        e.owner = owner;
        e.hits  = countHits(words[owner]);
        expGntQ.push_back(owner);
        expDoneQ.push_back(e);
    endtask

    task automatic waitGnt(input bit wasIdle);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (gnt == '0 && lat < WAIT_LIMIT);
        checkOutput("gnt_latency", 32'(lat), wasIdle ? 32'd1 : 32'd2);
    endtask

    // Called on a falling edge while IDLE or REPORT; returns on the falling edge of REPORT.
    task automatic applyStimulus(input logic [N_REQ-1:0] addReq,
                                 input logic [N_REQ*WORD_W-1:0] addData,
                                 input bit hold);
        int owner;
        int lat;
        bit wasIdle;
        for (int i = 0; i < N_REQ; i++)
            if (addReq[i] && !reqVec[i]) begin
                reqVec[i] = 1'b1;
                words[i]  = addData[i*WORD_W +: WORD_W];
            end
        driveBus();
        predict(owner);
        wasIdle = !busy;
        waitGnt(wasIdle);
        if (gnt == '0) return;
        if (!hold) begin
            reqVec[owner] = 1'b0;
            driveBus();
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (done == '0 && lat < WAIT_LIMIT);
        checkOutput("done_seen", 32'(done != '0), 32'd1);
`ifndef SEQDET_SCHED_FIXED_PRIO_EN
        ptrModel = (owner + 1) % N_REQ;
`endif
    endtask

    // Word is aborted at cycle 6 (inside SHIFT); the pending request stays up across reset.
    task automatic resetMidShift();
        int owner;
        expDone_t e;
        reqVec[0] = 1'b1;
        words[0]  = 8'b10010010;
        driveBus();
        predict(owner);
        waitGnt(!busy);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hit_cnt", 32'(hitCnt), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_det_rst", 32'(detRst), 32'd1);
        checkOutput("rst_det_j", 32'(detJ), 32'd0);
        if (expDoneQ.size() > 0) e = expDoneQ.pop_back();
        ptrModel = 0;
        repeat (2) @(negedge clk);
        checkOutput("rst_hold_done", 32'(done), 32'd0);
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge away from state updates.
    logic     prevRstN    = 1'b0;
    logic     clrExpected = 1'b0;
    int       gntCycle    = 0;
    int       lastHits    = 0;
    int       monOwner;
    expDone_t monExp;
    always @(negedge clk) begin
        cycle++;
        if (rst_n && prevRstN) begin
            checkOutput("det_rst_only_in_clr", 32'(detRst), 32'(clrExpected));
            clrExpected = 1'b0;
            if (gnt != '0) begin
                if (expGntQ.size() == 0)
                    checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
                else begin
                    monOwner = expGntQ.pop_front();
                    checkOutput("gnt", 32'(gnt), 32'd1 << monOwner);
                end
                gntCycle    = cycle;
                clrExpected = 1'b1;
            end
            if (done != '0) begin
                if (expDoneQ.size() == 0)
                    checkOutput("unexpected_done", 32'(done), 32'd0);
                else begin
                    monExp = expDoneQ.pop_front();
                    checkOutput("done", 32'(done), 32'd1 << monExp.owner);
                    checkOutput("hit_cnt", 32'(hitCnt), 32'(monExp.hits));
                    checkOutput("gnt_to_done", 32'(cycle - gntCycle), 32'(GNT_TO_DONE));
                    lastHits = monExp.hits;
                end
            end
            if (!busy)
                checkOutput("hit_cnt_held", 32'(hitCnt), 32'(lastHits));
        end else begin
            clrExpected = 1'b0;
            lastHits    = 0;
        end
        prevRstN = rst_n;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_REQ-1:0]        addReq;
        logic [N_REQ*WORD_W-1:0] addData;
        logic [WORD_W-1:0]       w;
        rst_n  = 1'b0;
        req    = '0;
        data   = '0;
        reqVec = '0;
        for (int i = 0; i < N_REQ; i++) words[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_hit_cnt", 32'(hitCnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_det_rst", 32'(detRst), 32'd1);
        checkOutput("reset_det_j", 32'(detJ), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed words");
        applyStimulus(4'b0001, slot(0, 8'b10010010), 1'b0);
        applyStimulus(4'b0010, slot(1, 8'h00), 1'b0);
        applyStimulus(4'b0100, slot(2, 8'b00001001), 1'b0);
        applyStimulus(4'b1000, slot(3, 8'b01000000), 1'b0);

        $display("[TB] all requesters held");
        applyStimulus(4'b1111, slot(0, 8'b10010010) | slot(1, 8'b01001000) |
                               slot(2, 8'b11111111) | slot(3, 8'b00100100), 1'b1);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b1);
        applyStimulus('0, '0, 1'b0);

        $display("[TB] reset during shift");
        resetMidShift();
        applyStimulus('0, '0, 1'b0);

        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            addReq  = N_REQ'($urandom_range(0, (1 << N_REQ) - 1));
            if ((reqVec | addReq) == '0)
                addReq[$urandom_range(0, N_REQ - 1)] = 1'b1;
            addData = '0;
            for (int i = 0; i < N_REQ; i++) begin
                case ($urandom_range(0, 3))
                    0:       w = 8'b10010010;
                    1:       w = 8'b01001000;
                    default: w = WORD_W'($urandom);
                endcase
                addData[i*WORD_W +: WORD_W] = w;
            end
            applyStimulus(addReq, addData, 1'b0);
        end
        for (int i = 0; i < N_REQ; i++)
            if (reqVec != '0) applyStimulus('0, '0, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("gnt_queue_drained", 32'(expGntQ.size()), 32'd0);
        checkOutput("done_queue_drained", 32'(expDoneQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/seqdet_sched.md
# seqdet_sched

Round-robin scheduler that shares one serial "10010" Mealy sequence detector among several requesters. Each requester presents a parallel word. The block grants one requester, clears the detector, and shifts that word MSB-first into the detector's serial input. It counts detector hits and reports the count back to the owner. It sits between the parallel producers and the single detector instance, which is connected through the `det_*` ports.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `WORD_W`, default 8: bits per word shifted into the detector, 5..32.
- `CNT_W`, default `$clog2(WORD_W+1)`: width of `hit_cnt`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (`rst`=0 resets the block).
- `req`  in  N_REQ: per-requester request level; held high until the matching `gnt` pulse.
- `data`  in  N_REQ*WORD_W: requester i's word is `data[i*WORD_W +: WORD_W]`; held stable while `req[i]` is high.
- `gnt`  out  N_REQ: one-hot, one-cycle pulse; `data` of the owner is captured on this cycle's closing edge.
- `done`  out  N_REQ: one-hot, one-cycle pulse to the owner when its word is finished.
- `hit_cnt`  out  CNT_W: number of detector hits for the last word; valid while `done` is high, then held.
- `busy`  out  1: high in every state except IDLE.
- `det_rst`  out  1: active-high reset to the detector.
- `det_j`  out  1: serial bit to the detector.
- `det_w`  in  1: detector Mealy output.

## Operation
- The FSM has five states: IDLE, GRANT, CLR, SHIFT, REPORT.
- IDLE
  - If `req` != 0, select the owner by arbitration, latch its index and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT
  - `gnt[owner]`=1.
  - Load `sh` <= owner's word and clear the hit counter.
  - Next state: CLR.
- CLR
  - `det_rst`=1 and `det_j`=0 for exactly one cycle.
  - Next state: SHIFT.
- SHIFT
  - `det_j` = `sh[WORD_W-1]`.
  - On each edge, shift `sh` left by 1 and decrement the bit counter.
  - If `det_w`=1 just before the edge, increment the hit counter.
  - After WORD_W edges, go to REPORT.
- REPORT
  - `done[owner]`=1 and present `hit_cnt`.
  - Advance the round-robin pointer to (owner+1) mod N_REQ.
  - Next state: IDLE.
- Arbitration (default): choose the first requester with `req` high, searching from the pointer upward with wrap-around. The pointer resets to 0.
- `det_w` is a Mealy output, so it is sampled only at the clock edge; combinational glitches are ignored.
- `det_rst` is low in every state except CLR and during block reset.
- `hit_cnt` cannot overflow, because hits per word are at most floor((WORD_W-2)/3).
- `req` changes after the owner is latched have no effect until the next IDLE.
  - A requester that keeps `req` high after `done` is treated as issuing a new request.

## Timing
- Reset values:
  - `gnt`=0, `done`=0, `hit_cnt`=0, `busy`=0.
  - `det_rst`=1 (the detector is held in reset while `rst`=0).
  - `det_j`=0.
  - State IDLE, pointer 0.
- Asserting `rst` mid-operation aborts immediately. The current word is lost: no `done` pulse and no pointer advance.
- Per-word timeline, with cycle 0 = first cycle with `req` seen in IDLE:
  - GRANT at cycle 1.
  - CLR at cycle 2.
  - SHIFT at cycles 3..WORD_W+2.
  - REPORT at cycle WORD_W+3.
- Cost per word is WORD_W+4 cycles. Back-to-back requests cost WORD_W+4 cycles each, since IDLE always takes one cycle.
- If several requests arrive in the same cycle, exactly one grant is issued; the others wait.
- All outputs are registered or decoded from the registered state only; there are no combinational paths from `req` or `det_w` to any output.

## Configuration
- `SEQDET_SCHED_FIXED_PRIO_EN`
  - Defined: fixed priority. The lowest asserted index always wins and the pointer is unused (held at 0).
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Bench connects the team's 10010 Mealy detector to `det_*`. Parameters: N_REQ=4, WORD_W=8.
- Single word with overlap: `req`=4'b0001, word0=8'b10010010 -> `gnt`=0001 at cycle 1, `done`=0001 at cycle 11, `hit_cnt`=2.
- No match: word1=8'h00, `req`=4'b0010 -> `done[1]` pulse with `hit_cnt`=0; `det_rst` high only in CLR.
- Round-robin: `req`=4'b1111 held -> grant order 0,1,2,3,0, with grants spaced 12 cycles apart.
  - Repeat with `SEQDET_SCHED_FIXED_PRIO_EN` defined -> grant order 0,0,0.
- Detector clear between words: word2=8'b00001001 followed by word3=8'b01000000 -> `hit_cnt`=0 for both. No carry-over hit across words.
- Reset mid-SHIFT: pull `rst` low at cycle 6 of a word -> all outputs at reset values, no `done` pulse. After release, pending `req[0]` is granted first.
